// File: rtl/fmeter_pkg.sv
// fmeter_pkg: shared FSM states, tuning-word width and k_est scaling for the frequency meter.
package fmeter_pkg;
  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
  localparam int KW_W = 32;
  function automatic logic [KW_W-1:0] k_of(input logic [KW_W-1:0] cnt, input int g);
    return cnt << (KW_W - g);
  endfunction
endpackage

// File: rtl/wave_edge_sync.sv
// wave_edge_sync: multi-flop synchronizer and rising-edge detector for an asynchronous input.
module wave_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic load_prev,
  output logic ws,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], async_in};
      prev <= ws;
    end
  end
  assign ws = sr[SYNC_STAGES-1];
  // load_prev treats history as equal to ws, so a level already high at gate open is not an edge
  assign rise = ws & ~prev & ~load_prev;
endmodule

// File: rtl/dds_freq_meter.sv
// dds_freq_meter: gated edge counter recovering a DDS tuning word from a square wave.
// FMETER_AUTO_RESTART_EN: when defined, gates run back-to-back after the first start.
module dds_freq_meter
  import fmeter_pkg::*;
#(
  parameter int GATE_LOG2 = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wave_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 valid,
  output logic [GATE_LOG2-1:0] edge_cnt,
  output logic [KW_W-1:0]      k_est
);
`ifdef FMETER_AUTO_RESTART_EN
  localparam state_t AFTER_DONE = GATE;
`else
  localparam state_t AFTER_DONE = IDLE;
`endif
  state_t state, nxt;
  logic [GATE_LOG2-1:0] gcnt, acc, total;
  logic ws_unused, rise, last;
  wave_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .async_in(wave_in),
    .load_prev(busy && gcnt == '0),
    .ws(ws_unused),
    .rise(rise)
  );
  always_comb begin
    busy = state == GATE;
    valid = state == DONE;
    last = gcnt == '1;
    total = acc + GATE_LOG2'(rise);
    nxt = state == IDLE ? (start ? GATE : IDLE) :
          state == GATE ? (last ? DONE : GATE) : AFTER_DONE;
  end
  // counters are held at zero outside the gate, so every gate entry starts clean
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gcnt <= '0;
      acc <= '0;
      edge_cnt <= '0;
      k_est <= '0;
    end else begin
      state <= nxt;
      gcnt <= busy ? gcnt + 1'b1 : '0;
      acc <= busy ? total : '0;
      if (busy && last) begin
        edge_cnt <= total;
        k_est <= k_of(KW_W'(total), GATE_LOG2);
      end
    end
  end
endmodule

// File: tb/tb_dds_freq_meter.sv
// tb_dds_freq_meter: directed checks of gate timing, edge counts and control for dds_freq_meter.
module tb_dds_freq_meter;
  logic clk = 0, rst = 1, wave_in = 0, start = 0, start2 = 0, wave2;
  logic busy, valid, busy2, valid2;
  logic [7:0] ec;
  logic [11:0] ec2;
  logic [31:0] k, k2;
  logic [31:0] ph = 0, dacc = 0;
  int mode = 0;
  int n_cmp = 0, n_bad = 0;
  int lat, bsy, nv;
  logic [7:0] held;

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    ph = ph + 1;
    dacc = dacc + 32'h0100_0000;
    wave_in = mode == 2 ? ph[3] : mode == 3 ? ph[0] : (mode == 1);
  end
  assign wave2 = dacc[31];

  dds_freq_meter #(.GATE_LOG2(8)) dut (
    .clk(clk), .rst(rst), .wave_in(wave_in), .start(start),
    .busy(busy), .valid(valid), .edge_cnt(ec), .k_est(k)
  );
  dds_freq_meter #(.GATE_LOG2(12)) dut2 (
    .clk(clk), .rst(rst), .wave_in(wave2), .start(start2),
    .busy(busy2), .valid(valid2), .edge_cnt(ec2), .k_est(k2)
  );

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
    longint d;
    d = got > exp ? got - exp : exp - got;
    n_cmp++;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tol 0x%0h)", tag, got, exp, tol);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int extra, output int l, output int b);
    l = 0;
    b = 0;
    start = 1;
    while (l < 400) begin
      tick;
      l++;
      start = extra != 0 && (l == 50 || l == 100);
      if (valid) break;
      b += int'(busy);
    end
    start = 0;
  endtask

  task automatic quiet(input int cycles, output int v);
    v = 0;
    repeat (cycles) begin
      tick;
      v += int'(valid);
    end
  endtask

  task automatic clear;
`ifdef FMETER_AUTO_RESTART_EN
    rst = 1;
    tick;
    rst = 0;
`endif
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cnt", ec, 0);
    chk("rst_k", k, 0);
    rst = 0;
    mode = 2;
    repeat (20) tick;
`ifdef FMETER_AUTO_RESTART_EN
    measure(0, lat, bsy);
    chk("ar_first_lat", lat, 257);
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        tick;
        lat++;
      end while (!valid && lat < 400);
      chk("ar_period", lat, 257);
      chk("ar_cnt", ec, 16, 1);
    end
    clear;
`endif
    measure(0, lat, bsy);
    chk("p16_lat", lat, 257);
    chk("p16_busy", bsy, 256);
    chk("p16_cnt", ec, 16, 1);
    chk("p16_k", k, 32'h1000_0000, 32'h0100_0000);
`ifndef FMETER_AUTO_RESTART_EN
    held = ec;
    quiet(50, nv);
    chk("hold_cnt", ec, held);
    chk("no_requeue", nv, 0);
`endif
    clear;
    mode = 1;
    repeat (10) tick;
    measure(0, lat, bsy);
    chk("hi_busy", bsy, 256);
    chk("hi_cnt", ec, 0);
    chk("hi_k", k, 0);
    clear;
    mode = 0;
    repeat (10) tick;
    measure(0, lat, bsy);
    chk("lo_busy", bsy, 256);
    chk("lo_cnt", ec, 0);
    chk("lo_k", k, 0);
    clear;
    mode = 3;
    repeat (10) tick;
    measure(0, lat, bsy);
    chk("tgl_lat", lat, 257);
    chk("tgl_cnt", ec, 128, 1);
    chk("tgl_k", k, 32'h8000_0000, 32'h0100_0000);
    clear;
    mode = 2;
    repeat (10) tick;
    measure(1, lat, bsy);
    chk("xs_lat", lat, 257);
    chk("xs_busy", bsy, 256);
`ifndef FMETER_AUTO_RESTART_EN
    quiet(300, nv);
    chk("xs_single", nv, 0);
`endif
    clear;
    start = 1;
    tick;
    start = 0;
    repeat (99) tick;
    rst = 1;
    tick;
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_cnt", ec, 0);
    chk("abort_k", k, 0);
    quiet(300, nv);
    chk("abort_novalid", nv, 0);
    measure(0, lat, bsy);
    chk("re_lat", lat, 257);
    chk("re_cnt", ec, 16, 1);
    clear;
    start2 = 1;
    tick;
    start2 = 0;
    lat = 1;
    while (!valid2 && lat < 5000) begin
      tick;
      lat++;
    end
    chk("dds_lat", lat, 4097);
    chk("dds_cnt", ec2, 16, 1);
    chk("dds_k", k2, 32'h0100_0000, 32'h0010_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
